// File: rtl/video_pll_pkg.sv
// Shared state encoding and default timing for the video PLL supervisor.
package video_pll_pkg;

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int DEF_LOSS_FILT_CYC    = 4;
  localparam int DEF_CNT_W            = 17;

endpackage

// File: rtl/video_pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into clk.
module video_pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/video_pll_rst_ctrl.sv
// PLL reset/lock supervisor releasing downstream video reset on stable lock.
// Optional RUN-state dropout filter: VIDEO_PLL_LOCK_FILT_EN.
module video_pll_rst_ctrl
  import video_pll_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOSS_FILT_CYC    = DEF_LOSS_FILT_CYC,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_cnt_o,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);

  logic             lock_s;
  logic             loss;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             pll_rst_q;
  logic             sys_rst_n_q;
  logic             lost_q, lost_d;

  video_pll_lock_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

`ifdef VIDEO_PLL_LOCK_FILT_EN
  localparam int FW = $clog2(LOSS_FILT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOSS_FILT_CYC - 1);

  logic [FW-1:0] filt_q, filt_d;

  always_comb begin
    filt_d = '0;
    loss   = 1'b0;
    if (state_q == ST_RUN && !lock_s) begin
      if (filt_q == FILT_LAST) loss = 1'b1;
      else filt_d = filt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) filt_q <= '0;
    else filt_q <= filt_d;
  end
`else
  assign loss = (state_q == ST_RUN) && !lock_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (loss) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase
  end

  // Outputs are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == ST_RESET_PLL);
      sys_rst_n_q <= (state_d == ST_RUN);
      lost_q      <= lost_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign lock_lost_o = lost_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_video_pll_rst_ctrl.sv
// Directed bench for video_pll_rst_ctrl using small timing parameters.
module tb_video_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_lost;
  logic [7:0] retry_cnt;
  logic [1:0] state;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       rst_n;
    logic       lock;
    logic [1:0] st;
    logic       pll;
    logic       sys;
    logic       lost;
    logic [7:0] retry;
  } vec_t;

  vec_t tbl[$];

  always #10 clk = ~clk;

  video_pll_rst_ctrl #(
    .RST_PULSE_CYC    (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32),
    .LOSS_FILT_CYC    (3),
    .CNT_W            (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock_i  (pll_lock),
    .pll_rst_o   (pll_rst),
    .sys_rst_n_o (sys_rst_n),
    .lock_lost_o (lock_lost),
    .retry_cnt_o (retry_cnt),
    .state_o     (state)
  );

  function automatic void add(input logic r, input logic l,
                              input logic [1:0] st, input logic p,
                              input logic s, input logic lo,
                              input logic [7:0] rc);
    vec_t v;
    v.rst_n = r; v.lock = l; v.st = st; v.pll = p;
    v.sys = s; v.lost = lo; v.retry = rc;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic l);
    @(negedge clk);
    rst_n = r;
    pll_lock = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] st,
                     input logic p, input logic s, input logic lo,
                     input logic [7:0] rc);
    nvec++;
    if (state !== st || pll_rst !== p || sys_rst_n !== s ||
        lock_lost !== lo || retry_cnt !== rc) begin
      nerr++;
      $display("FAIL %s: got st=%0d pll=%b sys=%b lost=%b retry=%0d, want st=%0d pll=%b sys=%b lost=%b retry=%0d",
               nm, state, pll_rst, sys_rst_n, lock_lost, retry_cnt,
               st, p, s, lo, rc);
    end
  endtask

  initial begin
    // Power-up and first lock.
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k <= 10; k++)
      add(1, 1, (k < 2) ? 2'd1 : (k < 10) ? 2'd2 : 2'd3,
          0, (k == 10), 0, 0);
    add(1, 1, 3, 0, 1, 0, 0);
    add(1, 1, 3, 0, 1, 0, 0);
`ifdef VIDEO_PLL_LOCK_FILT_EN
    add(1, 0, 3, 0, 1, 0, 0);
    add(1, 0, 3, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 3, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 3, 0, 1, 0, 0);
    add(1, 1, 3, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 2, 0, 0, 0, 0);
    add(1, 1, 3, 0, 1, 0, 0);
`else
    add(1, 0, 3, 0, 1, 0, 0);
    add(1, 1, 3, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 2, 0, 0, 0, 0);
    add(1, 1, 3, 0, 1, 0, 0);
`endif

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].lock);
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].pll,
          tbl[i].sys, tbl[i].lost, tbl[i].retry);
    end

    // Timeout retries with saturation.
    step(0, 0);
    chk("to_reset", 0, 1, 0, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      for (int j = 1; j <= 35; j++) begin
        step(1, 0);
        if (j == 35 && k <= 3)
          chk($sformatf("to_wait%0d", k), 1, 0, 0, 0, 8'(k - 1));
      end
      step(1, 0);
      chk($sformatf("to_edge%0d", k), 0, 1, 0, 0,
          (k > 255) ? 8'd255 : 8'(k));
    end

    // Lock after retries, then reset mid-STABLE.
    for (int i = 0; i < 7; i++) step(1, 1);
    chk("mid_stable", 2, 0, 0, 0, 255);
    step(0, 1);
    chk("rst_stable", 0, 1, 0, 0, 0);

    // Unstable lock: one-cycle dropout during STABLE.
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      chk("un_rst", 0, 1, 0, 0, 0);
    end
    step(1, 0);
    chk("un_wait", 1, 0, 0, 0, 0);
    for (int i = 0; i <= 16; i++) begin
      logic [1:0] es;
      step(1, (i != 5));
      if (i < 2) es = 2'd1;
      else if (i < 7) es = 2'd2;
      else if (i == 7) es = 2'd1;
      else if (i < 16) es = 2'd2;
      else es = 2'd3;
      chk($sformatf("unstable%0d", i), es, 0, (i == 16), 0, 0);
    end

    // Reset mid-RUN.
    step(1, 1);
    step(1, 1);
    chk("run_hold", 3, 0, 1, 0, 0);
    step(0, 1);
    chk("rst_run", 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
